// File: rtl/decode_fetch_stage_pkg.sv
// Shared decode constants and FSM state encoding for the decode/fetch stage.
// Imported by the operand_needs helper and the stage top.
package decode_pkg;

  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] OP_MOVR = 2'b00;
  localparam logic [1:0] OP_MVN  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD_A = 2'd1,
    S_RD_B = 2'd2,
    S_OUT  = 2'd3
  } state_t;

endpackage

// File: rtl/decode_fetch_stage_if.sv
// Instruction-in and decoded-bundle-out handshakes for decode_fetch_stage.
// slave: stage side; master: instruction source / execute side.
interface decode_fetch_stage_if #(
  parameter int DATA_W   = 16,
  parameter int REGSEL_W = 3
);
  logic                in_valid;
  logic                in_ready;
  logic [15:0]         instr;
  logic                out_valid;
  logic                out_ready;
  logic [2:0]          opcode;
  logic [1:0]          op;
  logic [1:0]          shift;
  logic [REGSEL_W-1:0] rn;
  logic [REGSEL_W-1:0] rd;
  logic [REGSEL_W-1:0] rm;
  logic [DATA_W-1:0]   sximm8;
  logic [DATA_W-1:0]   sximm5;
  logic [DATA_W-1:0]   a_val;
  logic [DATA_W-1:0]   b_val;
  logic                illegal;

  modport slave (
    input  in_valid, instr, out_ready,
    output in_ready, out_valid, opcode, op, shift,
    output rn, rd, rm, sximm8, sximm5,
    output a_val, b_val, illegal
  );

  modport master (
    output in_valid, instr, out_ready,
    input  in_ready, out_valid, opcode, op, shift,
    input  rn, rd, rm, sximm8, sximm5,
    input  a_val, b_val, illegal
  );
endinterface

// File: rtl/decode_fetch_stage_operand_needs.sv
// Which source registers an opcode/op pair reads, and whether it is legal.
// In: opcode, op. Out: needs_a, needs_b, b_is_rd, illegal.
module operand_needs
  import decode_pkg::*;
(
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       needs_a,
  output logic       needs_b,
  output logic       b_is_rd,
  output logic       illegal
);

  always_comb begin
    needs_a = 1'b0;
    needs_b = 1'b0;
    b_is_rd = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OPC_MOV: begin
        if (op == OP_MOVR) needs_b = 1'b1;
        else if (op != OP_MOVI) illegal = 1'b1;
      end
      OPC_ALU: begin
        needs_b = 1'b1;
        needs_a = (op != OP_MVN);
      end
      OPC_LDR: needs_a = 1'b1;
      OPC_STR: begin
        needs_a = 1'b1;
        needs_b = 1'b1;
        b_is_rd = 1'b1;
      end
      OPC_HALT: ;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_fetch_stage.sv
// Registered decode + operand fetch: captures one instruction, reads rn/rm/rd.
// Ports: clk, reset_n, flush, rf_readnum/rf_data, bus (in + bundle out).
module decode_fetch_stage
  import decode_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int REGSEL_W = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush,
  output logic [REGSEL_W-1:0] rf_readnum,
  input  logic [DATA_W-1:0]   rf_data,
  decode_fetch_stage_if.slave bus
);

  state_t            r_state;
  state_t            w_next;
  logic [15:0]       r_ir;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [15:0]       w_dec;
  logic              w_need_a;
  logic              w_need_b;
  logic              w_b_is_rd;
  logic              w_ill;

  // In IDLE the next state depends on the word being offered, not the IR.
  assign w_dec = (r_state == S_IDLE) ? bus.instr : r_ir;

  operand_needs u_needs (
    .opcode  (w_dec[15:13]),
    .op      (w_dec[12:11]),
    .needs_a (w_need_a),
    .needs_b (w_need_b),
    .b_is_rd (w_b_is_rd),
    .illegal (w_ill)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (bus.in_valid)
          w_next = w_need_a ? S_RD_A :
                   w_need_b ? S_RD_B : S_OUT;
      S_RD_A: w_next = w_need_b ? S_RD_B : S_OUT;
      S_RD_B: w_next = S_OUT;
      S_OUT:  if (bus.out_ready) w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ir <= '0;
      r_a  <= '0;
      r_b  <= '0;
    end else if (flush) begin
      r_a <= '0;
      r_b <= '0;
    end else begin
      unique case (r_state)
        S_IDLE:
          if (bus.in_valid) begin
            r_ir <= bus.instr;
            r_a  <= '0;
            r_b  <= '0;
          end
        S_RD_A: r_a <= rf_data;
        S_RD_B: r_b <= rf_data;
        S_OUT: ;
      endcase
    end
  end

  always_comb begin
    rf_readnum = '0;
    unique case (1'b1)
      r_state == S_RD_A:
        rf_readnum = REGSEL_W'(r_ir[10:8]);
      r_state == S_RD_B:
        rf_readnum = w_b_is_rd ? REGSEL_W'(r_ir[7:5])
                               : REGSEL_W'(r_ir[2:0]);
      default: ;
    endcase
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_OUT);
  // Reset IR decodes as opcode 000; only flag illegal on a real bundle.
  assign bus.illegal   = bus.out_valid & w_ill;
  assign bus.opcode    = r_ir[15:13];
  assign bus.op        = r_ir[12:11];
  assign bus.shift     = r_ir[4:3];
  assign bus.rn        = REGSEL_W'(r_ir[10:8]);
  assign bus.rd        = REGSEL_W'(r_ir[7:5]);
  assign bus.rm        = REGSEL_W'(r_ir[2:0]);
  assign bus.sximm8    = DATA_W'($signed(r_ir[7:0]));
  assign bus.sximm5    = DATA_W'($signed(r_ir[4:0]));
  assign bus.a_val     = r_a;
  assign bus.b_val     = r_b;

endmodule

// File: tb/tb_decode_fetch_stage.sv
// Directed bench for decode_fetch_stage at DATA_W=16 and DATA_W=32.
// Each step samples 1ns after the rising edge and drives the next inputs.
module tb_decode_fetch_stage;

  logic clk;
  logic reset_n;
  logic flush;
  logic flush32;
  logic [2:0] rnum;
  logic [2:0] rnum32;
  logic [15:0] rf [8];
  logic [31:0] rf32 [8];
  logic [15:0] rdat;
  logic [31:0] rdat32;
  int total;
  int bad;

  decode_fetch_stage_if #(.DATA_W(16), .REGSEL_W(3)) bus ();
  decode_fetch_stage_if #(.DATA_W(32), .REGSEL_W(3)) bus32 ();

  assign rdat   = rf[rnum];
  assign rdat32 = rf32[rnum32];

  decode_fetch_stage #(.DATA_W(16), .REGSEL_W(3)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .rf_readnum (rnum),
    .rf_data    (rdat),
    .bus        (bus)
  );

  decode_fetch_stage #(.DATA_W(32), .REGSEL_W(3)) dut32 (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush32),
    .rf_readnum (rnum32),
    .rf_data    (rdat32),
    .bus        (bus32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      rf[i]   = 16'h0;
      rf32[i] = 32'h0;
    end
    rf[1]   = 16'h0005;
    rf[2]   = 16'h1234;
    rf[3]   = 16'h0077;
    rf32[1] = 32'h8000_0000;
    reset_n = 1'b0;
    flush = 1'b0;
    flush32 = 1'b0;
    bus.in_valid = 1'b0;
    bus.instr = 16'h0;
    bus.out_ready = 1'b0;
    bus32.in_valid = 1'b0;
    bus32.instr = 16'h0;
    bus32.out_ready = 1'b0;

    // Reset state
    step();
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_illegal", bus.illegal, 0);
    check("rst_readnum", rnum, 0);
    check("rst_opcode", bus.opcode, 0);
    check("rst_sximm8", bus.sximm8, 0);
    reset_n = 1'b1;
    step();

    // MOV R2,#-10: no reads, OUT right after accept
    bus.in_valid = 1'b1;
    bus.instr = 16'hD2F6;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check("mov_out_valid", bus.out_valid, 1);
    check("mov_readnum", rnum, 0);
    check("mov_rn", bus.rn, 2);
    check("mov_sximm8", bus.sximm8, 32'h0000FFF6);
    check("mov_sximm5", bus.sximm5, 32'h0000FFF6);
    check("mov_illegal", bus.illegal, 0);
    check("mov_in_ready", bus.in_ready, 0);
    step();
    check("mov_back_idle", bus.in_ready, 1);

    // ADD R3,R1,R1 with reset pulsed during the rm read
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.instr = 16'hA161;
    step();
    bus.in_valid = 1'b0;
    check("rstmid_rda_num", rnum, 1);
    step();
    check("rstmid_rdb_num", rnum, 1);
    check("rstmid_a_loaded", bus.a_val, 32'h5);
    reset_n = 1'b0;
    #1;
    check("rstmid_in_ready", bus.in_ready, 1);
    check("rstmid_out_valid", bus.out_valid, 0);
    check("rstmid_a", bus.a_val, 0);
    check("rstmid_b", bus.b_val, 0);
    reset_n = 1'b1;
    step();

    // ADD R3,R1,R1 normally: 3 cycles to OUT
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.instr = 16'hA161;
    step();
    bus.in_valid = 1'b0;
    check("add_c1_num", rnum, 1);
    check("add_c1_ov", bus.out_valid, 0);
    step();
    check("add_c2_num", rnum, 1);
    check("add_c2_ov", bus.out_valid, 0);
    step();
    check("add_c3_ov", bus.out_valid, 1);
    check("add_a", bus.a_val, 32'h5);
    check("add_b", bus.b_val, 32'h5);
    check("add_illegal", bus.illegal, 0);
    check("add_rd", bus.rd, 3);
    check("add_out_num", rnum, 0);
    step();
    check("add_back_idle", bus.in_ready, 1);

    // STR R2,[R2] with 5 cycles of backpressure
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.instr = 16'h8240;
    step();
    bus.in_valid = 1'b0;
    check("str_rda_num", rnum, 2);
    step();
    check("str_rdb_num", rnum, 2);
    step();
    check("str_ov", bus.out_valid, 1);
    bus.in_valid = 1'b1;
    bus.instr = 16'hA161;
    for (int k = 0; k < 5; k++) begin
      step();
      check("str_hold_ov", bus.out_valid, 1);
      check("str_hold_ir", bus.in_ready, 0);
      check("str_hold_a", bus.a_val, 32'h1234);
      check("str_hold_b", bus.b_val, 32'h1234);
      check("str_hold_opc", bus.opcode, 3'b100);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    step();
    check("str_release_idle", bus.in_ready, 1);
    check("str_not_replaced", bus.opcode, 3'b100);

    // Illegal opcode 000
    bus.in_valid = 1'b1;
    bus.instr = 16'h1234;
    step();
    bus.in_valid = 1'b0;
    check("ill_ov", bus.out_valid, 1);
    check("ill_flag", bus.illegal, 1);
    check("ill_num", rnum, 0);
    step();

    // LDR R?,[R3] flushed in RD_A
    bus.in_valid = 1'b1;
    bus.instr = 16'h6300;
    step();
    bus.in_valid = 1'b0;
    check("ldr_rda_num", rnum, 3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_idle", bus.in_ready, 1);
    check("flush_ov", bus.out_valid, 0);
    check("flush_a", bus.a_val, 0);
    step();
    check("flush_stays_idle", bus.out_valid, 0);

    // flush with in_valid in IDLE: not accepted
    flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.instr = 16'hD2F6;
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_noaccept_ir", bus.in_ready, 1);
    check("flush_noaccept_opc", bus.opcode, 3'b011);

    // DATA_W=32: MOV R0,#-1 then ADD reading 32'h8000_0000
    bus32.out_ready = 1'b1;
    bus32.in_valid = 1'b1;
    bus32.instr = 16'hD0FF;
    step();
    bus32.in_valid = 1'b0;
    check("w32_mov_ov", bus32.out_valid, 1);
    check("w32_mov_sximm8", bus32.sximm8, 32'hFFFFFFFF);
    step();
    bus32.in_valid = 1'b1;
    bus32.instr = 16'hA161;
    step();
    bus32.in_valid = 1'b0;
    step();
    step();
    check("w32_add_ov", bus32.out_valid, 1);
    check("w32_add_a", bus32.a_val, 32'h8000_0000);
    check("w32_add_b", bus32.b_val, 32'h8000_0000);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
